// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned radix-2 restoring divider for the EX stage.
// Produces {remainder, quotient} 33 cycles after start; supports annul from a pipeline flush.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        result_ready,
  output logic        div_stallreq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t state, state_next;

  logic [4:0]  cnt;
  // Upper bit of the 33-bit partial remainder is always zero between steps, so only 32 bits are stored.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        sgn_op;
  logic        neg_dvd;
  logic        neg_dvs;

  logic        start_ok;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] sh_rem;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] q_out;
  logic [31:0] r_out;

  always_comb begin
    start_ok = div_start & ~annul;
    mag1     = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
    mag2     = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    sh_rem   = {rem, quo[31]};
    diff     = sh_rem - {1'b0, dvsr};
    fits     = ~diff[32];
    q_fin    = {quo[30:0], fits};
    r_fin    = fits ? diff[31:0] : sh_rem[31:0];
    q_out    = (sgn_op && (neg_dvd ^ neg_dvs)) ? (32'd0 - q_fin) : q_fin;
    r_out    = (sgn_op && neg_dvd) ? (32'd0 - r_fin) : r_fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    div_stallreq = div_start & ~annul & (state != S_END);
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_next = (opdata2 == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        state_next = annul ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul) begin
          state_next = S_IDLE;
        end else if (cnt == 5'd31) begin
          state_next = S_END;
        end
      end
      S_END: begin
        if (annul || !div_start) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      sgn_op       <= 1'b0;
      neg_dvd      <= 1'b0;
      neg_dvs      <= 1'b0;
      result       <= '0;
      result_ready <= 1'b0;
    end else begin
      result_ready <= (state_next == S_END);
      case (state)
        S_IDLE: begin
          if (start_ok && (opdata2 != 32'd0)) begin
            rem     <= '0;
            quo     <= mag1;
            dvsr    <= mag2;
            sgn_op  <= signed_div;
            neg_dvd <= opdata1[31];
            neg_dvs <= opdata2[31];
            cnt     <= '0;
          end
        end
        S_DIVZERO: begin
          result <= '0;
        end
        S_ON: begin
          if (annul) begin
            result <= '0;
          end else begin
            rem <= r_fin;
            quo <= q_fin;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= {r_out, q_out};
            end
          end
        end
        S_END: begin
          if (annul) begin
            result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue and popped on result_ready.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        result_ready;
  logic        div_stallreq;

  int n_checks;
  int n_fail;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .signed_div   (signed_div),
    .annul        (annul),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .result       (result),
    .result_ready (result_ready),
    .div_stallreq (div_stallreq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: divide magnitudes, then apply DIV sign rules modulo 2^32.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'h0;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na != nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Drives one divide at negedge T, waits for result_ready, then drops div_start like EX does.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output logic [63:0] res, output int stall_err,
                        output logic ready_hold, output logic ready_after);
    stall_err   = 0;
    lat         = -1;
    ready_hold  = 1'b0;
    ready_after = 1'b1;
    res         = 'x;
    @(negedge clk);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    div_start  = 1'b1;
    #1;
    if (div_stallreq !== 1'b1) stall_err++;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        opdata1    = ~a;
        opdata2    = $urandom;
        signed_div = ~sgn;
      end
      if (result_ready === 1'b1) begin
        lat = n;
        break;
      end
      if (div_stallreq !== 1'b1) stall_err++;
    end
    if (lat < 0) begin
      div_start = 1'b0;
      return;
    end
    res = result;
    if (div_stallreq !== 1'b0) stall_err++;
    @(negedge clk);
    ready_hold = result_ready;
    div_start  = 1'b0;
    @(negedge clk);
    ready_after = result_ready;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    div_start  = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    @(negedge clk);
    n_checks++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", result, 64'h0); end
    n_checks++;
    if (result_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", result_ready); end
    n_checks++;
    if (div_stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", div_stallreq); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    int lat, se;
    logic [63:0] res, exp;
    logic rh, ra;
    exp_q.push_back(64'h00000002_0000000E);
    do_div(32'h64, 32'h7, 1'b0, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL divu_result: got %h expected %h", res, exp); end
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    n_checks++;
    if (se != 0) begin n_fail++; $display("FAIL divu_stallreq: got %0d bad cycles expected 0", se); end
    n_checks++;
    if (rh !== 1'b1) begin n_fail++; $display("FAIL divu_ready_hold: got %b expected 1", rh); end
    n_checks++;
    if (ra !== 1'b0) begin n_fail++; $display("FAIL divu_ready_fall: got %b expected 0", ra); end
  endtask

  task automatic test_div_signed();
    int lat, se;
    logic [63:0] res, exp;
    logic rh, ra;
    exp_q.push_back(64'hFFFFFFFE_FFFFFFF2);
    do_div(32'hFFFF_FF9C, 32'h7, 1'b1, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL div_signed_result: got %h expected %h", res, exp); end
    n_checks++;
    if (lat != 33 || se != 0) begin n_fail++; $display("FAIL div_signed_timing: got lat %0d stall_err %0d expected 33 0", lat, se); end
  endtask

  task automatic test_boundaries();
    int lat, se;
    logic [63:0] res, exp;
    logic rh, ra;
    exp_q.push_back(64'h00000000_80000000);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp || lat != 33) begin n_fail++; $display("FAIL div_overflow: got %h lat %0d expected %h lat 33", res, lat, exp); end
    exp_q.push_back(64'h00000000_FFFFFFFF);
    do_div(32'hFFFF_FFFF, 32'h1, 1'b0, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp || lat != 33) begin n_fail++; $display("FAIL divu_max: got %h lat %0d expected %h lat 33", res, lat, exp); end
  endtask

  task automatic test_divzero_back_to_back();
    int lat, se;
    logic [63:0] res, exp;
    logic rh, ra;
    exp_q.push_back(64'h0);
    do_div(32'h1234, 32'h0, 1'b0, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL divzero_result: got %h expected %h", res, exp); end
    n_checks++;
    if (lat != 2 || se != 0 || rh !== 1'b1 || ra !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_timing: got lat %0d stall_err %0d hold %b fall %b expected 2 0 1 0", lat, se, rh, ra);
    end
    exp_q.push_back(model(32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1));
    do_div(32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp || lat != 33) begin n_fail++; $display("FAIL back_to_back: got %h lat %0d expected %h lat 33", res, lat, exp); end
  endtask

  task automatic test_annul();
    int lat, se, spurious;
    logic [63:0] res, exp;
    logic rh, ra;
    @(negedge clk);
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    div_start  = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    n_checks++;
    if (div_stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_stall_mask: got %b expected 0", div_stallreq); end
    @(negedge clk);
    n_checks++;
    if (result_ready !== 1'b0 || result !== 64'h0) begin
      n_fail++;
      $display("FAIL annul_clear: got ready %b result %h expected 0 %h", result_ready, result, 64'h0);
    end
    annul     = 1'b0;
    div_start = 1'b0;
    spurious  = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_ready !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin n_fail++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", spurious); end
    exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
    do_div(32'd1000, 32'd3, 1'b0, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp || lat != 33 || se != 0) begin
      n_fail++;
      $display("FAIL annul_restart: got %h lat %0d stall_err %0d expected %h lat 33 0", res, lat, se, exp);
    end
  endtask

  task automatic test_async_reset();
    int lat, se, waited;
    logic [63:0] res, exp;
    logic rh, ra;
    @(negedge clk);
    opdata1    = 32'd77;
    opdata2    = 32'd5;
    signed_div = 1'b0;
    div_start  = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (result !== 64'h0 || result_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_on: got result %h ready %b expected %h 0", result, result_ready, 64'h0);
    end
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    opdata1   = 32'd50;
    opdata2   = 32'd7;
    div_start = 1'b1;
    waited    = 0;
    while (result_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (result !== 64'h00000001_00000007 || waited != 33) begin
      n_fail++;
      $display("FAIL pre_reset_result: got %h after %0d cycles expected %h after 33", result, waited, 64'h00000001_00000007);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (result !== 64'h0 || result_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_end: got result %h ready %b expected %h 0", result, result_ready, 64'h0);
    end
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    exp_q.push_back(64'h00000000_00000003);
    do_div(32'd9, 32'd3, 1'b0, lat, res, se, rh, ra);
    exp = exp_q.pop_front();
    n_checks++;
    if (res !== exp || lat != 33) begin n_fail++; $display("FAIL post_reset_div: got %h lat %0d expected %h lat 33", res, lat, exp); end
  endtask

  task automatic test_random();
    int lat, se;
    logic [63:0] res, exp;
    logic rh, ra;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = (i % 2 == 0) ? $urandom_range(1, 300) : $urandom;
      if (i % 4 == 3) b = 32'd0 - b;
      if (b == 32'd0) b = 32'd1;
      sgn = i[1] ^ i[0];
      exp_q.push_back(model(a, b, sgn));
      do_div(a, b, sgn, lat, res, se, rh, ra);
      exp = exp_q.pop_front();
      n_checks++;
      if (res !== exp || lat != 33 || se != 0) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h s=%b got %h lat %0d stall_err %0d expected %h lat 33 0",
                 i, a, b, sgn, res, lat, se, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_boundaries();
    test_divzero_back_to_back();
    test_annul();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider serving the EX stage of the five-stage MIPS pipeline. EX issues DIV/DIVU operands, holds the pipeline through `stallreq_for_ex` while this block computes, then writes the 64-bit result into HI/LO. The core is radix-2 restoring, one quotient bit per cycle. It supports annulment from a pipeline flush.

## Interface
- No parameters; operand width fixed at 32 bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `div_start`  in  1  EX requests a divide; held high until the cycle after `result_ready`.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `div_start` in IDLE.
- `annul`  in  1  abort the current operation; overrides `div_start`.
- `opdata1`  in  32  dividend; sampled only in IDLE on start.
- `opdata2`  in  32  divisor; sampled only in IDLE on start.
- `result`  out  64  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO.
- `result_ready`  out  1  registered; high while in END.
- `div_stallreq`  out  1  combinational; equals `div_start & ~annul & (state != END)`. EX ORs it into `stallreq_for_ex`.

## Operation
- States are IDLE, DIVZERO, ON and END. State, counter, operand registers and outputs are all registers.
- **IDLE**
  - On `div_start & ~annul` with `opdata2 == 0`, go to DIVZERO.
  - On `div_start & ~annul` with a nonzero divisor, go to ON. Latch the magnitudes of both operands, where magnitude = two's-complement negation when `signed_div` is set and bit 31 is 1. Latch `signed_div`, both sign bits, and cnt ← 0.
  - Otherwise stay in IDLE.
- **DIVZERO**: go to END with result ← 64'h0.
- **ON**: one step per cycle.
  - Shift the 65-bit working register {rem[32:0], quo[31:0]} left by 1.
  - Trial-subtract the divisor magnitude from rem.
  - If the difference is non-negative, rem ← difference and the quotient LSB ← 1. Otherwise the LSB ← 0.
  - cnt ← cnt+1. At cnt == 31 the step completes and the state goes to END.
  - On that last edge, result ← sign-corrected value:
    - quotient is negated when signed and the operand signs differ;
    - remainder is negated when signed and the dividend is negative.
- **END**
  - `result_ready` = 1 and `result` is stable.
  - If `div_start` is low, go to IDLE, and `result_ready` falls on that edge. Otherwise stay in END.
  - A new division therefore requires one IDLE cycle.
- **annul**: in any state other than IDLE, go to IDLE on the next edge with `result_ready` ← 0 and result ← 0. In IDLE, `annul` blocks the start.
- **Width and arithmetic rules**
  - Subtraction is 33-bit (rem[32:0] minus {1'b0, divisor}).
  - All negations are modulo 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is the natural wrap; no exception is raised.
- Operand inputs changing after the start cycle have no effect.
- **Reset**: state IDLE, cnt 0, working registers 0, `result` 64'h0, `result_ready` 0. Reset applied mid-operation discards the operation.

## Timing
- Cycle T is IDLE with `div_start` high and a nonzero divisor. `div_stallreq` is high in T.
- ON occupies T+1 through T+32 (32 steps).
- END starts at T+33. From T+33, `result_ready` = 1, `result` is valid and `div_stallreq` = 0.
- EX captures HI/LO in T+33 and drops `div_start` in T+34. State is IDLE from T+35.
- Divide by zero: DIVZERO at T+1, END at T+2 with result 0.
- `annul` asserted in cycle A (not IDLE) gives IDLE at A+1. `div_stallreq` is low in cycle A because `annul` masks it.
- No combinational path exists from inputs to `result` or `result_ready`. The only combinational output is `div_stallreq`.

## Test plan
- DIVU 0x0000_0064 / 0x0000_0007, start at T: `result` = {0x0000_0002, 0x0000_000E}. `result_ready` rises exactly at T+33, and `div_stallreq` is high for T..T+32.
- DIV 0xFFFF_FF9C (−100) / 0x0000_0007: quotient 0xFFFF_FFF2 (−14), remainder 0xFFFF_FFFE (−2).
- DIV 0x8000_0000 / 0xFFFF_FFFF: quotient 0x8000_0000, remainder 0. DIVU 0xFFFF_FFFF / 0x1: quotient 0xFFFF_FFFF, remainder 0.
- Divide by zero: DIVU 0x1234 / 0 gives `result_ready` at T+2 with `result` 64'h0. A back-to-back second divide issued after one IDLE cycle completes correctly.
- `annul` pulsed at T+10: IDLE at T+11, `result_ready` stays 0, `result` = 0. The next start completes normally with 33-cycle latency.
- Reset asserted asynchronously at T+20 (mid-ON): outputs clear immediately without waiting for a clock edge. After deassertion, a new DIVU 9/3 returns {0, 3}.
